// File: rtl/qsram_ctrl_pkg.sv
// Shared types and defaults for the QSRAM controller and its refresh timer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package qsram_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WRITE     = 3'd1,
        READ      = 3'd2,
        READ_WAIT = 3'd3,
        REFRESH   = 3'd4
    } state_t;

    localparam int DEF_ADDR_WIDTH     = 4;
    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_REFRESH_PERIOD = 64;
    localparam int DEF_REFRESH_CYCLES = 2;

    // Counter width able to hold 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/qsram_refresh_timer.sv
// Free-running refresh interval counter with a sticky pending flag.
// Latency: RefreshPending rises on the edge where the counter wraps to 0.
// Backpressure: none; the flag simply stays set until acknowledged.
module qsram_refresh_timer
    import qsram_ctrl_pkg::*;
#(
    parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD
) (
    input  logic Clock,
    input  logic Reset_n,
    input  logic RefreshAck,
    output logic RefreshPending
);

    localparam int              CW   = cnt_width(REFRESH_PERIOD);
    localparam logic [CW-1:0]   LAST = CW'(REFRESH_PERIOD - 1);

    logic [CW-1:0] count;
    logic          wrap;

    assign wrap = (count == LAST);

    // Interval counter runs regardless of controller state.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            count <= '0;
        end else if (wrap) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // A wrap always (re)arms the flag, so a wrap on top of an existing
    // request collapses into that single outstanding refresh.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            RefreshPending <= 1'b0;
        end else if (wrap) begin
            RefreshPending <= 1'b1;
        end else if (RefreshAck) begin
            RefreshPending <= 1'b0;
        end
    end

endmodule

// File: rtl/qsram_controller.sv
// Single-port QSRAM controller: host req/rsp to array strobes plus periodic refresh.
// Latency: write 1 cycle; read data valid the cycle after acceptance edge + 2.
// Backpressure: ReqReady only in IDLE with no refresh pending; refresh preempts new requests.
module qsram_controller
    import qsram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD,
    parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic                  ReqValid,
    output logic                  ReqReady,
    input  logic                  ReqWrite,
    input  logic [ADDR_WIDTH-1:0] ReqAddress,
    input  logic [DATA_WIDTH-1:0] ReqWriteData,
    output logic                  RspValid,
    output logic [DATA_WIDTH-1:0] RspReadData,
    output logic [ADDR_WIDTH-1:0] MemAddress,
    output logic                  MemEnable,
    output logic                  MemRead,
    output logic                  MemWrite,
    output logic                  MemRefresh,
    inout  wire  [DATA_WIDTH-1:0] MemData
);

    localparam int            RCW      = cnt_width(REFRESH_CYCLES);
    localparam logic [RCW-1:0] REF_LAST = RCW'(REFRESH_CYCLES - 1);

    state_t                state;
    state_t                state_next;
    logic                  ready_en;
    logic                  accept;
    logic                  refresh_pending;
    logic                  refresh_ack;
    logic [RCW-1:0]        ref_cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  mem_drive;

    qsram_refresh_timer #(
        .REFRESH_PERIOD (REFRESH_PERIOD)
    ) u_refresh_timer (
        .Clock          (Clock),
        .Reset_n        (Reset_n),
        .RefreshAck     (refresh_ack),
        .RefreshPending (refresh_pending)
    );

    // Array data bus is only ever driven while writing.
    assign MemData = mem_drive ? wdata_q : {DATA_WIDTH{1'bz}};

    // State register.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Holds ReqReady low until the first edge after reset release.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Command capture at acceptance; direction lives in the state register.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            addr_q  <= ReqAddress;
            wdata_q <= ReqWriteData;
        end
    end

    // Refresh burst length counter, cleared whenever not refreshing.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            ref_cnt <= '0;
        end else if (state == REFRESH) begin
            ref_cnt <= ref_cnt + 1'b1;
        end else begin
            ref_cnt <= '0;
        end
    end

    // Read data is captured on the edge leaving READ_WAIT and held until the next read.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            RspValid    <= 1'b0;
            RspReadData <= '0;
        end else begin
            RspValid <= (state == READ_WAIT);
            if (state == READ_WAIT) begin
                RspReadData <= MemData;
            end
        end
    end

    // Next-state and array strobe decode.
    always_comb begin
        state_next  = state;
        ReqReady    = 1'b0;
        accept      = 1'b0;
        refresh_ack = 1'b0;
        MemEnable   = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemRefresh  = 1'b0;
        MemAddress  = '0;
        mem_drive   = 1'b0;
        case (state)
            IDLE: begin
                ReqReady = ready_en && !refresh_pending;
                if (refresh_pending) begin
                    refresh_ack = 1'b1;
                    state_next  = REFRESH;
                end else if (ReqValid && ReqReady) begin
                    accept     = 1'b1;
                    state_next = ReqWrite ? WRITE : READ;
                end
            end
            WRITE: begin
                MemEnable  = 1'b1;
                MemWrite   = 1'b1;
                MemAddress = addr_q;
                mem_drive  = 1'b1;
                state_next = IDLE;
            end
            READ: begin
                MemEnable  = 1'b1;
                MemRead    = 1'b1;
                MemAddress = addr_q;
                state_next = READ_WAIT;
            end
            READ_WAIT: begin
                state_next = IDLE;
            end
            REFRESH: begin
                MemEnable  = 1'b1;
                MemRefresh = 1'b1;
                if (ref_cnt == REF_LAST) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_qsram_controller.sv
// Self-checking bench for qsram_controller with a simple array model and read scoreboard.
// Latency: n/a.
// Backpressure: requests are held until ReqReady, with a bounded wait.
module tb_qsram_controller;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam logic [DW-1:0] IDLE_PAT = 8'h3C;

    logic          Clock;
    logic          Reset_n;
    logic          ReqValid;
    logic          ReqReady;
    logic          ReqWrite;
    logic [AW-1:0] ReqAddress;
    logic [DW-1:0] ReqWriteData;
    logic          RspValid;
    logic [DW-1:0] RspReadData;
    logic [AW-1:0] MemAddress;
    logic          MemEnable;
    logic          MemRead;
    logic          MemWrite;
    logic          MemRefresh;
    wire  [DW-1:0] MemData;

    qsram_controller #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .REFRESH_PERIOD (64),
        .REFRESH_CYCLES (2)
    ) dut (
        .Clock        (Clock),
        .Reset_n      (Reset_n),
        .ReqValid     (ReqValid),
        .ReqReady     (ReqReady),
        .ReqWrite     (ReqWrite),
        .ReqAddress   (ReqAddress),
        .ReqWriteData (ReqWriteData),
        .RspValid     (RspValid),
        .RspReadData  (RspReadData),
        .MemAddress   (MemAddress),
        .MemEnable    (MemEnable),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .MemRefresh   (MemRefresh),
        .MemData      (MemData)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int n_acc    = 0;
    int n_rsp    = 0;
    int last_ref = -1;
    int rsp_cycs[$];

    typedef struct {
        logic [DW-1:0] dat;
        int            acc;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    logic [DW-1:0] ref_mem [16];

    // Array model: one-cycle registered read, idle pattern on the bus when nobody drives.
    logic [DW-1:0] mem [16];
    logic          rd_vld = 1'b0;
    logic [DW-1:0] rd_dat = '0;
    always @(posedge Clock) begin
        rd_vld <= MemEnable && MemRead;
        rd_dat <= mem[MemAddress];
        if (MemEnable && MemWrite) mem[MemAddress] <= MemData;
    end
    assign MemData = (MemEnable && MemWrite) ? {DW{1'bz}} : (rd_vld ? rd_dat : IDLE_PAT);

    always @(posedge Clock) cyc <= cyc + 1;

    // Monitor: strobe legality, acceptance/refresh bookkeeping, response scoreboard.
    always @(negedge Clock) begin
        if (Reset_n) begin
            if (ReqValid && ReqReady) n_acc++;
            if (MemRefresh) last_ref = cyc;
            checks++;
            if ($countones({MemRead, MemWrite, MemRefresh}) > 1 ||
                MemEnable != (MemRead | MemWrite | MemRefresh)) begin
                failures++;
                $display("FAIL strobes cyc=%0d got en=%b rd=%b wr=%b rf=%b exp one-hot-or-zero with enable",
                         cyc, MemEnable, MemRead, MemWrite, MemRefresh);
            end
            if (RspValid) begin
                n_rsp++;
                rsp_cycs.push_back(cyc);
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rsp_unexpected cyc=%0d got data=%0h exp no response", cyc, RspReadData);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (RspReadData !== mon_e.dat) begin
                        failures++;
                        $display("FAIL rsp_data got=%0h exp=%0h", RspReadData, mon_e.dat);
                    end
                    checks++;
                    if (cyc - mon_e.acc != 2) begin
                        failures++;
                        $display("FAIL rsp_latency got=%0d exp=2 edges after accept", cyc - mon_e.acc);
                    end
                end
            end
        end
    end

    // Present a request at posedge+1 and hold it until accepted; returns acceptance edge index.
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d, output int acc);
        int n;
        exp_t e;
        n = 0;
        ReqValid = 1'b1; ReqWrite = wr; ReqAddress = a; ReqWriteData = d;
        @(negedge Clock);
        while (!ReqReady && n < 200) begin
            @(negedge Clock);
            n++;
        end
        if (!ReqReady) begin
            checks++; failures++;
            $display("FAIL accept_timeout got ready=0 exp ready=1 within 200 cycles");
        end
        @(posedge Clock); #1;
        acc = cyc;
        if (wr) begin
            ref_mem[a] = d;
        end else begin
            e.dat = ref_mem[a];
            e.acc = acc;
            exp_q.push_back(e);
        end
        ReqValid = 1'b0;
    endtask

    task automatic do_reset(output int rel);
        Reset_n = 1'b0;
        exp_q.delete();
        repeat (3) @(posedge Clock);
        #1;
        Reset_n = 1'b1;
        rel = cyc;
    endtask

    task automatic test_reset();
        int rel;
        ReqValid = 1'b0; ReqWrite = 1'b0; ReqAddress = '0; ReqWriteData = '0;
        Reset_n = 1'b0;
        #1;
        checks++;
        if ({ReqReady, RspValid, RspReadData, MemEnable, MemRead, MemWrite, MemRefresh, MemAddress} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got rdy=%b rv=%b rd=%0h en=%b r=%b w=%b f=%b a=%0h exp all 0",
                     ReqReady, RspValid, RspReadData, MemEnable, MemRead, MemWrite, MemRefresh, MemAddress);
        end
        repeat (2) @(posedge Clock);
        #1;
        checks++;
        if (MemData !== IDLE_PAT) begin
            failures++;
            $display("FAIL reset_bus got=%0h exp=%0h (released)", MemData, IDLE_PAT);
        end
        Reset_n = 1'b1;
        rel = cyc;
        @(negedge Clock);
        checks++;
        if (ReqReady !== 1'b0) begin
            failures++;
            $display("FAIL ready_before_edge got=%b exp=0", ReqReady);
        end
        @(negedge Clock);
        checks++;
        if (ReqReady !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_edge got=%b exp=1", ReqReady);
        end
        @(posedge Clock); #1;
    endtask

    task automatic test_write();
        int acc;
        issue(1'b1, 4'd3, 8'hA5, acc);
        @(negedge Clock);
        checks++;
        if (MemEnable !== 1'b1 || MemWrite !== 1'b1 || MemAddress !== 4'd3 || MemData !== 8'hA5) begin
            failures++;
            $display("FAIL write_cycle got en=%b wr=%b a=%0h d=%0h exp en=1 wr=1 a=3 d=a5",
                     MemEnable, MemWrite, MemAddress, MemData);
        end
        @(negedge Clock);
        checks++;
        if (MemData !== IDLE_PAT || MemEnable !== 1'b0) begin
            failures++;
            $display("FAIL write_release got d=%0h en=%b exp d=%0h en=0", MemData, MemEnable, IDLE_PAT);
        end
        checks++;
        if (mem[3] !== 8'hA5) begin
            failures++;
            $display("FAIL write_array got=%0h exp=a5", mem[3]);
        end
        @(posedge Clock); #1;
    endtask

    task automatic test_read();
        int acc;
        int r0;
        issue(1'b1, 4'd3, 8'h5A, acc);
        r0 = n_rsp;
        issue(1'b0, 4'd3, 8'h00, acc);
        repeat (6) @(posedge Clock);
        #1;
        checks++;
        if (n_rsp - r0 != 1) begin
            failures++;
            $display("FAIL read_pulses got=%0d exp=1", n_rsp - r0);
        end
        checks++;
        if (RspReadData !== 8'h5A || RspValid !== 1'b0) begin
            failures++;
            $display("FAIL read_hold got data=%0h rv=%b exp data=5a rv=0", RspReadData, RspValid);
        end
    endtask

    task automatic test_back_to_back();
        int rel;
        int acc[3];
        int r0;
        int k;
        do_reset(rel);
        issue(1'b1, 4'd0, 8'h11, acc[0]);
        issue(1'b1, 4'd1, 8'h22, acc[0]);
        issue(1'b1, 4'd2, 8'h33, acc[0]);
        r0 = n_rsp;
        for (int i = 0; i < 3; i++) issue(1'b0, AW'(i), 8'h00, acc[i]);
        for (int i = 1; i < 3; i++) begin
            checks++;
            if (acc[i] - acc[i-1] != 3) begin
                failures++;
                $display("FAIL b2b_issue got=%0d exp=3", acc[i] - acc[i-1]);
            end
        end
        repeat (6) @(posedge Clock);
        #1;
        checks++;
        if (n_rsp - r0 != 3) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=3", n_rsp - r0);
        end else begin
            k = rsp_cycs.size();
            for (int i = k - 2; i < k; i++) begin
                checks++;
                if (rsp_cycs[i] - rsp_cycs[i-1] != 3) begin
                    failures++;
                    $display("FAIL b2b_rsp_gap got=%0d exp=3", rsp_cycs[i] - rsp_cycs[i-1]);
                end
            end
        end
    endtask

    task automatic test_refresh();
        int rel;
        int cnt_a;
        int cnt_b;
        int stray;
        cnt_a = 0; cnt_b = 0; stray = 0;
        do_reset(rel);
        while (cyc < rel + 140) begin
            @(negedge Clock);
            if (cyc == rel + 64) begin
                checks++;
                if (ReqReady !== 1'b0) begin
                    failures++;
                    $display("FAIL refresh_pending_ready got=%b exp=0", ReqReady);
                end
            end
            if (MemRefresh) begin
                checks++;
                if (ReqReady !== 1'b0 || MemAddress !== '0 || MemEnable !== 1'b1) begin
                    failures++;
                    $display("FAIL refresh_cycle got rdy=%b a=%0h en=%b exp rdy=0 a=0 en=1",
                             ReqReady, MemAddress, MemEnable);
                end
                if (cyc == rel + 65 || cyc == rel + 66) cnt_a++;
                else if (cyc == rel + 129 || cyc == rel + 130) cnt_b++;
                else stray++;
            end
        end
        checks++;
        if (cnt_a != 2 || cnt_b != 2 || stray != 0) begin
            failures++;
            $display("FAIL refresh_schedule got first=%0d second=%0d stray=%0d exp 2 2 0", cnt_a, cnt_b, stray);
        end
        @(posedge Clock); #1;
    endtask

    task automatic test_collision();
        int rel;
        int acc;
        int a0;
        int r0;
        do_reset(rel);
        issue(1'b1, 4'd6, 8'hC3, acc);
        while (cyc < rel + 64) begin
            @(posedge Clock); #1;
        end
        a0 = n_acc;
        r0 = n_rsp;
        issue(1'b0, 4'd6, 8'h00, acc);
        checks++;
        if (acc != rel + 68) begin
            failures++;
            $display("FAIL collision_accept got=%0d exp=%0d", acc - rel, 68);
        end
        checks++;
        if (last_ref != rel + 66) begin
            failures++;
            $display("FAIL collision_refresh_first got=%0d exp=%0d", last_ref - rel, 66);
        end
        repeat (5) @(posedge Clock);
        #1;
        checks++;
        if (n_acc - a0 != 1 || n_rsp - r0 != 1) begin
            failures++;
            $display("FAIL collision_count got acc=%0d rsp=%0d exp 1 1", n_acc - a0, n_rsp - r0);
        end
    endtask

    task automatic test_reset_read_wait();
        int acc;
        int r0;
        issue(1'b0, 4'd6, 8'h00, acc);
        r0 = n_rsp;
        @(posedge Clock);
        #2;
        Reset_n = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if ({ReqReady, RspValid, RspReadData, MemEnable, MemRead, MemWrite, MemRefresh, MemAddress} !== '0) begin
            failures++;
            $display("FAIL rst_rw_outputs got rdy=%b rv=%b rd=%0h en=%b r=%b w=%b f=%b a=%0h exp all 0",
                     ReqReady, RspValid, RspReadData, MemEnable, MemRead, MemWrite, MemRefresh, MemAddress);
        end
        repeat (3) @(posedge Clock);
        #1;
        checks++;
        if (MemData !== IDLE_PAT || RspValid !== 1'b0) begin
            failures++;
            $display("FAIL rst_rw_hold got d=%0h rv=%b exp d=%0h rv=0", MemData, RspValid, IDLE_PAT);
        end
        Reset_n = 1'b1;
        @(negedge Clock);
        @(negedge Clock);
        checks++;
        if (ReqReady !== 1'b1) begin
            failures++;
            $display("FAIL rst_rw_ready got=%b exp=1", ReqReady);
        end
        repeat (4) @(negedge Clock);
        checks++;
        if (n_rsp != r0) begin
            failures++;
            $display("FAIL rst_rw_no_rsp got=%0d exp=0", n_rsp - r0);
        end
        @(posedge Clock); #1;
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_refresh();
        test_collision();
        test_reset_read_wait();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0 outstanding", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
